// File: rtl/computation_layer_drain_pkg.sv
// Shared constants for the layer drain: data width, FSM encodings, index-width helper.
`ifndef FIELD_ARITH_DEFS_SV
`include "field_arith_defs.sv"
`endif

package computation_layer_drain_pkg;

  localparam int DATA_W = `F_NBITS;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/computation_layer_drain_ctr.sv
// Iteration-major / gate-minor index pair for the drain stream; clr has priority over inc.
module computation_layer_drain_ctr #(
  parameter int ngates     = 8,
  parameter int nIters     = 1,
  parameter int nCountBits = 1,
  parameter int ngbits     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  output logic [nCountBits-1:0] iter,
  output logic [ngbits-1:0]     gate,
  output logic                  last
);

  localparam logic [ngbits-1:0]     GATE_MAX = ngbits'(ngates - 1);
  localparam logic [nCountBits-1:0] ITER_MAX = nCountBits'(nIters - 1);

  logic [nCountBits-1:0] iter_q, iter_d;
  logic [ngbits-1:0]     gate_q, gate_d;

  always_comb begin
    iter_d = iter_q;
    gate_d = gate_q;
    if (clr) begin
      iter_d = '0;
      gate_d = '0;
    end else if (inc) begin
      if (gate_q == GATE_MAX) begin
        gate_d = '0;
        iter_d = (iter_q == ITER_MAX) ? '0 : iter_q + nCountBits'(1);
      end else begin
        gate_d = gate_q + ngbits'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_q <= '0;
      gate_q <= '0;
    end else begin
      iter_q <= iter_d;
      gate_q <= gate_d;
    end
  end

  assign iter = iter_q;
  assign gate = gate_q;
  assign last = (iter_q == ITER_MAX) && (gate_q == GATE_MAX);

endmodule

// File: rtl/field_arith_defs.sv
// Shared field-arithmetic definitions: width of one field element.
`ifndef FIELD_ARITH_DEFS_SV
`define FIELD_ARITH_DEFS_SV
`define F_NBITS 32
`endif

// File: rtl/computation_layer_drain.sv
// Snapshots a layer's outputs on load and streams them one word per cycle over valid/ready.
// A load coinciding with the final transfer chains straight into the next snapshot.
module computation_layer_drain
  import computation_layer_drain_pkg::*;
#(
  parameter int  ngates     = 8,
  parameter int  nIters     = 1,
  parameter int  nCountBits = 1,
  localparam int ngbits     = idx_bits(ngates)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         load,
  input  logic [nIters-1:0][ngates-1:0][DATA_W-1:0]    v_in,
  output logic [DATA_W-1:0]                            out_data,
  output logic [nCountBits-1:0]                        out_iter,
  output logic [ngbits-1:0]                            out_gate,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic                                         out_last,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         overrun
);

  if (ngates < 1 || nIters < 1 || nCountBits < 1 ||
      (nIters > 1 && nCountBits < $clog2(nIters))) begin : g_param_err
    $error("computation_layer_drain: illegal ngates/nIters/nCountBits combination");
  end

  logic [0:0] state_q, state_d;
  logic       done_q, done_d;
  logic       overrun_q, overrun_d;
  logic [nIters-1:0][ngates-1:0][DATA_W-1:0] snap_q, snap_d;

  logic                  xfer, last_xfer, accept;
  logic [nCountBits-1:0] ctr_iter;
  logic [ngbits-1:0]     ctr_gate;
  logic                  ctr_last;

  always_comb begin
    xfer      = (state_q == ST_STREAM) && out_ready;
    last_xfer = xfer && ctr_last;
    // A load is taken when idle, or exactly as the final word leaves.
    accept    = load && ((state_q == ST_IDLE) || last_xfer);
    state_d   = state_q;
    if (accept) begin
      state_d = ST_STREAM;
    end else if (last_xfer) begin
      state_d = ST_IDLE;
    end
    snap_d    = accept ? v_in : snap_q;
    done_d    = last_xfer;
    overrun_d = overrun_q | (load & ~accept);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  // Snapshot is data-only; its contents are meaningless until the first load.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

  computation_layer_drain_ctr #(
    .ngates    (ngates),
    .nIters    (nIters),
    .nCountBits(nCountBits),
    .ngbits    (ngbits)
  ) u_ctr (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .inc (xfer),
    .iter(ctr_iter),
    .gate(ctr_gate),
    .last(ctr_last)
  );

  assign out_data  = snap_q[ctr_iter][ctr_gate];
  assign out_iter  = ctr_iter;
  assign out_gate  = ctr_gate;
  assign out_last  = ctr_last;
  assign busy      = (state_q == ST_STREAM);
  assign out_valid = busy;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_computation_layer_drain.sv
// Scoreboard bench: 4x2 drain for streaming/stall/overrun/chain/reset cases, 1x1 drain for the degenerate case.
`timescale 1ns/1ps
module tb_computation_layer_drain;
  import computation_layer_drain_pkg::*;

  localparam int DW = DATA_W;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [0:0]    iter;
    logic [1:0]    gate;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic load_a = 1'b0, ready_a = 1'b0;
  logic load_b = 1'b0, ready_b = 1'b0;
  logic [1:0][3:0][DW-1:0] vin_a = '0;
  logic [0:0][0:0][DW-1:0] vin_b = '0;

  logic [DW-1:0] data_a, data_b;
  logic [0:0]    iter_a, iter_b;
  logic [1:0]    gate_a;
  logic [0:0]    gate_b;
  logic valid_a, last_a, busy_a, done_a, ovr_a;
  logic valid_b, last_b, busy_b, done_b, ovr_b;

  computation_layer_drain #(.ngates(4), .nIters(2), .nCountBits(1)) dut_a (
    .clk(clk), .rst(rst), .load(load_a), .v_in(vin_a),
    .out_data(data_a), .out_iter(iter_a), .out_gate(gate_a), .out_valid(valid_a),
    .out_ready(ready_a), .out_last(last_a), .busy(busy_a), .done(done_a), .overrun(ovr_a)
  );

  computation_layer_drain #(.ngates(1), .nIters(1), .nCountBits(1)) dut_b (
    .clk(clk), .rst(rst), .load(load_b), .v_in(vin_b),
    .out_data(data_b), .out_iter(iter_b), .out_gate(gate_b), .out_valid(valid_b),
    .out_ready(ready_b), .out_last(last_b), .busy(busy_b), .done(done_b), .overrun(ovr_b)
  );

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   pend_done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic fill_a(input int off);
    for (int i = 0; i < 2; i++)
      for (int g = 0; g < 4; g++)
        vin_a[i][g] = DW'(16 * i + g + 1 + off);
  endtask

  task automatic push_a(input int off);
    exp_t e;
    for (int i = 0; i < 2; i++)
      for (int g = 0; g < 4; g++) begin
        e.data = DW'(16 * i + g + 1 + off);
        e.iter = 1'(i);
        e.gate = 2'(g);
        e.last = (i == 1) && (g == 3);
        q.push_back(e);
      end
  endtask

  // Mid-cycle check of dut_a against the scoreboard; a transfer pops the head.
  task automatic sample();
    exp_t e;
    #4;
    chk("valid", valid_a, q.size() != 0);
    chk("busy", busy_a, q.size() != 0);
    chk("done", done_a, pend_done);
    pend_done = 1'b0;
    if (q.size() != 0 && valid_a === 1'b1) begin
      e = q[0];
      chk("data", data_a, e.data);
      chk("iter", iter_a, e.iter);
      chk("gate", gate_a, e.gate);
      chk("last", last_a, e.last);
      if (ready_a) begin
        e = q.pop_front();
        pend_done = e.last;
      end
    end
  endtask

  task automatic step(input bit push, input int off);
    sample();
    @(posedge clk);
    #1;
    if (push) push_a(off);
  endtask

  task automatic drain(input int budget, output int n);
    n = 0;
    while (q.size() != 0 && n < budget) begin
      step(1'b0, 0);
      n++;
    end
    chk("drain_budget", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Reset values
    chk("rst_valid", valid_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_ovr", ovr_a, 1'b0);
    chk("rst_iter", iter_a, 1'b0);
    chk("rst_gate", gate_a, 2'd0);
    chk("rst_valid_b", valid_b, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-rate stream
    ready_a = 1'b1;
    fill_a(0);
    load_a = 1'b1;
    step(1'b1, 0);
    load_a = 1'b0;
    drain(20, n);
    chk("t1_cycles", n, 8);
    step(1'b0, 0);
    step(1'b0, 0);

    // Stall pattern 1,0,0,1,...
    load_a = 1'b1;
    step(1'b1, 0);
    load_a = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      ready_a = (n % 3 == 0);
      step(1'b0, 0);
      n++;
    end
    chk("t2_budget", q.size(), 0);
    ready_a = 1'b1;
    step(1'b0, 0);
    chk("t2_ovr", ovr_a, 1'b0);

    // Ignored load during word 3
    load_a = 1'b1;
    step(1'b1, 0);
    load_a = 1'b0;
    step(1'b0, 0);
    step(1'b0, 0);
    fill_a(50);
    load_a = 1'b1;
    step(1'b0, 0);
    load_a = 1'b0;
    chk("t3_ovr_set", ovr_a, 1'b1);
    drain(20, n);
    step(1'b0, 0);
    chk("t3_ovr_hold", ovr_a, 1'b1);

    // Load coincident with the final transfer
    fill_a(0);
    load_a = 1'b1;
    step(1'b1, 0);
    load_a = 1'b0;
    n = 0;
    while (q.size() > 1 && n < 20) begin
      step(1'b0, 0);
      n++;
    end
    chk("t4_budget", q.size(), 1);
    fill_a(100);
    load_a = 1'b1;
    step(1'b1, 100);
    load_a = 1'b0;
    drain(20, n);
    chk("t4_cycles", n, 8);
    step(1'b0, 0);
    chk("t4_ovr_hold", ovr_a, 1'b1);

    // Reset mid-stream after word 2
    fill_a(0);
    load_a = 1'b1;
    step(1'b1, 0);
    load_a = 1'b0;
    step(1'b0, 0);
    step(1'b0, 0);
    rst = 1'b1;
    #1;
    chk("t5_valid", valid_a, 1'b0);
    chk("t5_busy", busy_a, 1'b0);
    chk("t5_done", done_a, 1'b0);
    chk("t5_ovr", ovr_a, 1'b0);
    chk("t5_iter", iter_a, 1'b0);
    chk("t5_gate", gate_a, 2'd0);
    q.delete();
    pend_done = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    step(1'b0, 0);
    load_a = 1'b1;
    step(1'b1, 0);
    load_a = 1'b0;
    drain(20, n);
    chk("t5_cycles", n, 8);
    step(1'b0, 0);

    // Degenerate 1x1 instance
    vin_b[0][0] = DW'(7);
    ready_b = 1'b1;
    load_b = 1'b1;
    @(posedge clk); #1;
    load_b = 1'b0;
    chk("b_valid", valid_b, 1'b1);
    chk("b_data", data_b, DW'(7));
    chk("b_last", last_b, 1'b1);
    chk("b_iter", iter_b, 1'b0);
    chk("b_gate", gate_b, 1'b0);
    @(posedge clk); #1;
    chk("b_done", done_b, 1'b1);
    chk("b_idle", valid_b, 1'b0);
    @(posedge clk); #1;
    chk("b_done_clr", done_b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
